// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_MEM  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  // funct3 encodings; the store forms reuse the B/H/W values
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Major opcodes that route an instruction to this unit
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Stores only have the signed B/H/W forms; loads add the unsigned B/H forms
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: legality, alignment, store strobes/lanes
// and load extraction for a 32-bit word bus.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  // Decode legality and natural alignment of the access size
  always_comb begin
    illegal    = !f3_legal(is_store, funct3);
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = |addr_lo;
      default:     misaligned = 1'b0;
    endcase
  end

  // Place store data on every lane it could land in and enable the addressed bytes
  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = 32'h0000_0000;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wstrb      = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_H: begin
          wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        F3_W: begin
          wstrb      = 4'b1111;
          wdata_lane = wdata;
        end
        default: begin
          wstrb      = 4'b0000;
          wdata_lane = 32'h0000_0000;
        end
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0 and sign- or zero-extend it
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    rdata_ext = 32'h0000_0000;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_ext = shifted;
      F3_BU:   rdata_ext = {24'h00_0000, shifted[7:0]};
      F3_HU:   rdata_ext = {16'h0000, shifted[15:0]};
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access from the core, drives a
// valid/ready word-wide memory port and returns a one-cycle response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t  state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        is_store_q;

  logic        al_is_store;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata_lane;
  logic [31:0] al_rdata_ext;
  logic        al_misaligned;
  logic        al_illegal;

  assign req_ready = (state == LSU_IDLE);

  // In IDLE the lane logic looks at the live request; afterwards at the captured one
  always_comb begin
    al_is_store = is_store_q;
    al_funct3   = funct3_q;
    al_addr_lo  = addr_lo_q;
    if (state == LSU_IDLE) begin
      al_is_store = req_is_store;
      al_funct3   = req_funct3;
      al_addr_lo  = req_addr[1:0];
    end
  end

  load_store_unit_align u_align (
    .is_store   (al_is_store),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata_lane),
    .rdata_ext  (al_rdata_ext),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  // Access sequencer with registered memory and response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= LSU_IDLE;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      is_store_q <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            funct3_q   <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            is_store_q <= req_is_store;
            if (al_illegal || al_misaligned) begin
              state     <= LSU_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= LSU_MEM;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wstrb <= al_wstrb;
              mem_wdata <= al_wdata_lane;
            end
          end
        end
        LSU_MEM: begin
          if (mem_ready) begin
            state     <= LSU_RESP;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= is_store_q ? '0 : al_rdata_ext;
          end
        end
        LSU_RESP: begin
          state     <= LSU_IDLE;
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= LSU_IDLE;
          mem_valid <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// accesses compared against a byte-level behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        mem_seen;
    logic [31:0] maddr;
    logic [3:0]  mstrb;
    logic [31:0] mwdata;
    logic        stable;
    logic        ready_low;
    int          rsp_count;
    int          rsp_lat;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Byte-level model: access size, legality, lanes and extension from first principles
  function automatic void ref_access(input logic st, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     input logic [31:0] rd, output logic err,
                                     output logic [3:0] strb, output logic [31:0] lane,
                                     output logic [31:0] res);
    int   size;
    int   off;
    logic legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off   = int'(addr[1:0]);
    err   = !legal || ((off % size) != 0);
    strb  = 4'b0000;
    lane  = 32'h0;
    res   = 32'h0;
    if (!err && st) begin
      for (int i = 0; i < 4; i++) begin
        lane[8*i +: 8] = wd[8*(i % size) +: 8];
        if (i >= off && i < off + size) strb[i] = 1'b1;
      end
    end
    if (!err && !st) begin
      for (int i = 0; i < size; i++) res[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!f3[2] && size < 4 && res[8*size-1])
        for (int i = size; i < 4; i++) res[8*i +: 8] = 8'hFF;
    end
  endfunction

  // Issue one access and record what the DUT does (no judgement here)
  task automatic drive_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int stall,
                              input logic hold, output obs_t o);
    o           = '0;
    o.stable    = 1'b1;
    o.ready_low = 1'b1;
    o.rsp_lat   = -1;
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    mem_rdata    = rd;
    mem_ready    = 1'b0;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    for (int n = 0; n < 60; n++) begin
      if (mem_valid) begin
        if (!o.mem_seen) begin
          o.mem_seen = 1'b1;
          o.maddr    = mem_addr;
          o.mstrb    = mem_wstrb;
          o.mwdata   = mem_wdata;
        end else if (mem_addr !== o.maddr || mem_wstrb !== o.mstrb || mem_wdata !== o.mwdata) begin
          o.stable = 1'b0;
        end
      end
      if (o.rsp_count == 0 && req_ready !== 1'b0) o.ready_low = 1'b0;
      if (rsp_valid === 1'b1) begin
        if (o.rsp_count == 0) begin
          o.rsp_lat = n;
          o.rdata   = rsp_rdata;
          o.err     = rsp_error;
        end
        o.rsp_count++;
        req_valid = 1'b0;
      end
      if (o.rsp_count > 0 && n > o.rsp_lat + 2) break;
      mem_ready = (n >= stall) && (o.rsp_count == 0);
      if (hold && o.rsp_count == 0) req_addr = $urandom;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0040;
    req_wdata    = 32'h1234_5678;
    mem_ready    = 1'b1;
    mem_rdata    = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (mem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_valid: got %b expected 0", mem_valid); end
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_flags: got valid=%b error=%b expected 0/0", rsp_valid, rsp_error); end
    tests_run++;
    if (rsp_rdata !== 32'h0 || mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got rdata=%h addr=%h expected 0/0", rsp_rdata, mem_addr); end
    tests_run++;
    if (mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_wr: got wstrb=%b wdata=%h expected 0/0", mem_wstrb, mem_wdata); end
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    obs_t o;
    drive_access(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, o);
    tests_run++;
    if (o.mem_seen !== 1'b1 || o.maddr !== 32'h10 || o.mstrb !== 4'b1111) begin tests_failed++; $display("[TB] FAIL sw_mem: got seen=%b addr=%h strb=%b expected 1/00000010/1111", o.mem_seen, o.maddr, o.mstrb); end
    tests_run++;
    if (o.mwdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", o.mwdata); end
    tests_run++;
    if (o.rsp_count != 1 || o.rsp_lat != 1 || o.err !== 1'b0 || o.rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL sw_rsp: got count=%0d lat=%0d err=%b rdata=%h expected 1/1/0/0", o.rsp_count, o.rsp_lat, o.err, o.rdata); end
    drive_access(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 2, 1'b0, o);
    tests_run++;
    if (o.maddr !== 32'h10 || o.mstrb !== 4'b1000 || o.mwdata !== 32'hA5A5_A5A5) begin tests_failed++; $display("[TB] FAIL sb_mem: got addr=%h strb=%b wdata=%h expected 00000010/1000/a5a5a5a5", o.maddr, o.mstrb, o.mwdata); end
    tests_run++;
    if (o.rsp_count != 1 || o.rsp_lat != 3 || o.err !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_rsp: got count=%0d lat=%0d err=%b expected 1/3/0", o.rsp_count, o.rsp_lat, o.err); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [5] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h0};
    logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      drive_access(1'b0, f3s[i], 32'h0000_0100 | ads[i], 32'h0, 32'h80FF_7F01, i % 3, 1'b0, o);
      tests_run++;
      if (o.rsp_count != 1 || o.err !== 1'b0 || o.rdata !== exps[i]) begin tests_failed++; $display("[TB] FAIL load_ext_%0d: got count=%0d err=%b rdata=%h expected 1/0/%h", i, o.rsp_count, o.err, o.rdata, exps[i]); end
      tests_run++;
      if (o.maddr !== 32'h100 || o.mstrb !== 4'b0000) begin tests_failed++; $display("[TB] FAIL load_mem_%0d: got addr=%h strb=%b expected 00000100/0000", i, o.maddr, o.mstrb); end
    end
  endtask

  task automatic test_errors();
    logic        sts[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s[5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
    logic [31:0] ads[5] = '{32'h6, 32'h1, 32'h0, 32'h0, 32'h3};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      drive_access(sts[i], f3s[i], ads[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, o);
      tests_run++;
      if (o.mem_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_nomem_%0d: got mem_valid seen=%b expected 0", i, o.mem_seen); end
      tests_run++;
      if (o.rsp_count != 1 || o.rsp_lat != 0 || o.err !== 1'b1 || o.rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL err_rsp_%0d: got count=%0d lat=%0d err=%b rdata=%h expected 1/0/1/0", i, o.rsp_count, o.rsp_lat, o.err, o.rdata); end
    end
  endtask

  task automatic test_stall_hold();
    obs_t o;
    drive_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hCAFE_1234, 5, 1'b1, o);
    tests_run++;
    if (o.stable !== 1'b1 || o.maddr !== 32'h2000) begin tests_failed++; $display("[TB] FAIL stall_stable: got stable=%b addr=%h expected 1/00002000", o.stable, o.maddr); end
    tests_run++;
    if (o.ready_low !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_req_ready: got ready_low=%b expected 1", o.ready_low); end
    tests_run++;
    if (o.rsp_count != 1 || o.rsp_lat != 6 || o.rdata !== 32'hFFFF_CAFE) begin tests_failed++; $display("[TB] FAIL stall_rsp: got count=%0d lat=%0d rdata=%h expected 1/6/ffffcafe", o.rsp_count, o.rsp_lat, o.rdata); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   stray;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0020;
    mem_ready    = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (mem_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_started: got mem_valid=%b expected 1", mem_valid); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_abort: got mem_valid=%b req_ready=%b rsp_valid=%b expected 0/1/0", mem_valid, req_ready, rsp_valid); end
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    stray     = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) stray++;
    end
    mem_ready = 1'b0;
    tests_run++;
    if (stray != 0) begin tests_failed++; $display("[TB] FAIL rstmid_no_rsp: got %0d active cycles expected 0", stray); end
    drive_access(1'b0, 3'b100, 32'h0000_0021, 32'h0, 32'h1122_3344, 1, 1'b0, o);
    tests_run++;
    if (o.rsp_count != 1 || o.err !== 1'b0 || o.rdata !== 32'h0000_0033) begin tests_failed++; $display("[TB] FAIL rstmid_next: got count=%0d err=%b rdata=%h expected 1/0/00000033", o.rsp_count, o.err, o.rdata); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd, lane, res;
    logic [3:0]  strb;
    logic        err;
    int          stall;
    for (int i = 0; i < 60; i++) begin
      st    = 1'($urandom);
      f3    = 3'($urandom);
      addr  = $urandom;
      wd    = $urandom;
      rd    = $urandom;
      stall = int'($urandom_range(0, 3));
      ref_access(st, f3, addr, wd, rd, err, strb, lane, res);
      drive_access(st, f3, addr, wd, rd, stall, 1'($urandom), o);
      tests_run++;
      if (o.rsp_count != 1 || o.err !== err) begin tests_failed++; $display("[TB] FAIL rand_%0d_rsp: got count=%0d err=%b expected 1/%b (st=%b f3=%b addr=%h)", i, o.rsp_count, o.err, err, st, f3, addr); end
      tests_run++;
      if (o.rdata !== (st ? 32'h0 : res)) begin tests_failed++; $display("[TB] FAIL rand_%0d_rdata: got %h expected %h (f3=%b addr=%h rd=%h)", i, o.rdata, st ? 32'h0 : res, f3, addr, rd); end
      tests_run++;
      if (o.rsp_lat != (err ? 0 : stall + 1) || o.mem_seen !== !err) begin tests_failed++; $display("[TB] FAIL rand_%0d_timing: got lat=%0d mem=%b expected %0d/%b", i, o.rsp_lat, o.mem_seen, err ? 0 : stall + 1, !err); end
      if (!err) begin
        tests_run++;
        if (o.maddr !== {addr[31:2], 2'b00} || o.mstrb !== strb || (st && o.mwdata !== lane)) begin tests_failed++; $display("[TB] FAIL rand_%0d_mem: got addr=%h strb=%b wdata=%h expected %h/%b/%h", i, o.maddr, o.mstrb, o.mwdata, {addr[31:2], 2'b00}, strb, lane); end
      end
    end
  endtask

  // Hard stop in case the DUT wedges somewhere no bounded wait covers
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_store();
    test_load_extend();
    test_errors();
    test_stall_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
